// File: rtl/param_rom_stream_ctrl.sv
// param_rom_stream_ctrl
//   Credit-controlled read sequencer for a synchronous parameter ROM. It walks
//   addresses 0..DEPTH-1 a programmable number of times. It tracks the fixed ROM
//   read latency with a tag pipeline and buffers the returned words in a small
//   first-word-fall-through FIFO. The FIFO output is presented as a valid/ready
//   stream with a per-pass last marker.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, num_passes   job request (sampled in IDLE), pass count latched on start
//   busy, done          busy outside IDLE; done pulses one cycle at job end
//   rom_addr, rom_ce    ROM read address and clock enable
//   rom_q               ROM read data, ROM_LATENCY cycles after address
//   data_out*           output stream (data, valid, ready, last)
module param_rom_stream_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 24,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int PASS_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic [PASS_WIDTH-1:0]   pass_cnt;
  logic [PASS_WIDTH-1:0]   passes_q;

  // Tag pipeline: index 0 is one cycle after issue, ROM_LATENCY-1 lines up with rom_q.
  logic [ROM_LATENCY-1:0]  vld_p;
  logic [ROM_LATENCY-1:0]  last_p;

  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic                    fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        inflight;

  logic                    issue;
  logic                    at_last_addr;
  logic                    final_issue;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld_p[i]);
    end
  end

  // Credits use start-of-cycle counts only; a pop in this cycle frees space next cycle.
  assign issue        = (state == FETCH) && ((fifo_count + inflight) < CNT_W'(FIFO_DEPTH));
  assign at_last_addr = (addr_cnt == ADDR_WIDTH'(DEPTH - 1));
  assign final_issue  = issue && at_last_addr && (pass_cnt == passes_q - 1'b1);
  assign fifo_empty   = (fifo_count == '0);
  assign push         = vld_p[ROM_LATENCY-1];
  assign pop          = !fifo_empty && data_out_ready;

  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign rom_ce         = (state == FETCH) || (state == DRAIN);
  assign rom_addr       = addr_cnt;
  assign data_out_valid = !fifo_empty;
  assign data_out       = fifo_data[rd_ptr];
  assign data_out_last  = fifo_last[rd_ptr];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_passes == '0) ? DONE : FETCH;
      FETCH:   if (final_issue) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && fifo_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: address issue, pass counting, tag entry into the latency pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_cnt <= '0;
      pass_cnt <= '0;
      passes_q <= '0;
      vld_p    <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        addr_cnt <= '0;
        pass_cnt <= '0;
        passes_q <= num_passes;
      end else if (issue) begin
        if (at_last_addr) begin
          addr_cnt <= '0;
          pass_cnt <= pass_cnt + 1'b1;
        end else begin
          addr_cnt <= addr_cnt + 1'b1;
        end
      end
      // Tags advance in lock-step with the ROM pipeline, which only moves while ce=1.
      if (rom_ce) begin
        vld_p[0] <= issue;
        for (int i = 1; i < ROM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rom_ce) begin
      last_p[0] <= at_last_addr;
      for (int i = 1; i < ROM_LATENCY; i++) last_p[i] <= last_p[i-1];
    end
  end

  // Stage p1: ROM word capture into the FWFT buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Words arriving during reset belong to the abandoned job and are dropped.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_data[wr_ptr] <= rom_q;
      fifo_last[wr_ptr] <= last_p[ROM_LATENCY-1];
    end
  end

endmodule
